// File: rtl/alu_share_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Op selects are one-hot; bit 0 is add.
package alu_share_pkg;

    localparam int DW  = 32;
    localparam int OPW = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = 12'b0000_0000_0001;
    localparam logic [OPW-1:0] OP_SUB  = 12'b0000_0000_0010;
    localparam logic [OPW-1:0] OP_AND  = 12'b0000_0000_0100;
    localparam logic [OPW-1:0] OP_OR   = 12'b0000_0000_1000;
    localparam logic [OPW-1:0] OP_XOR  = 12'b0000_0001_0000;
    localparam logic [OPW-1:0] OP_NOR  = 12'b0000_0010_0000;
    localparam logic [OPW-1:0] OP_SLL  = 12'b0000_0100_0000;
    localparam logic [OPW-1:0] OP_SRL  = 12'b0000_1000_0000;
    localparam logic [OPW-1:0] OP_SRA  = 12'b0001_0000_0000;
    localparam logic [OPW-1:0] OP_SLT  = 12'b0010_0000_0000;
    localparam logic [OPW-1:0] OP_SLTU = 12'b0100_0000_0000;
    localparam logic [OPW-1:0] OP_PASS = 12'b1000_0000_0000;

endpackage

// File: rtl/alu32.sv
// Combinational 32-bit ALU with a one-hot op select; any select that is not
// a recognised one-hot code produces zero.
module alu32
    import alu_share_pkg::*;
(
    input  logic [DW-1:0]  a,
    input  logic [DW-1:0]  b,
    input  logic [OPW-1:0] f,
    output logic [DW-1:0]  y
);

    always_comb begin
        y = '0;
        case (f)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOR:  y = ~(a | b);
            OP_SLL:  y = a << b[4:0];
            OP_SRL:  y = a >> b[4:0];
            OP_SRA:  y = $signed(a) >>> b[4:0];
            OP_SLT:  y = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
            OP_SLTU: y = {{(DW-1){1'b0}}, a < b};
            OP_PASS: y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on contention the requester named by ptr wins,
// otherwise the lone valid requester is granted.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    assign grant[0] = req[0] & (~req[1] | ~ptr);
    assign grant[1] = req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU between two valid/ready requesters: round-robin accept,
// one-cycle execute from registered operands, then hold the tagged result.
module alu_share_arbiter
    import alu_share_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [2*DW-1:0]  req_a,
    input  logic [2*DW-1:0]  req_b,
    input  logic [2*OPW-1:0] req_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [DW-1:0]    rsp_y,
    output logic             rsp_err,
    output logic             busy
);

    state_t         state_reg;
    logic           rr_ptr_reg;
    logic           accept_en_reg;
    logic           id_reg;
    logic           op_err_reg;
    logic [DW-1:0]  a_reg;
    logic [DW-1:0]  b_reg;
    logic [OPW-1:0] op_reg;
    logic           rsp_valid_reg;
    logic           rsp_id_reg;
    logic [DW-1:0]  rsp_y_reg;
    logic           rsp_err_reg;
    logic           busy_reg;

    logic [DW-1:0]  a_arr  [2];
    logic [DW-1:0]  b_arr  [2];
    logic [OPW-1:0] op_arr [2];
    logic [1:0]     grant;
    logic           sel_id;
    logic           handshake;
    logic [DW-1:0]  alu_y;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign a_arr[gi]  = req_a[gi*DW +: DW];
            assign b_arr[gi]  = req_b[gi*DW +: DW];
            assign op_arr[gi] = req_op[gi*OPW +: OPW];
        end
    endgenerate

    rr_arbiter2 u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr_reg),
        .grant (grant)
    );

    // accept_en_reg keeps ready low while reset is held and for the first cycle after
    assign req_ready = (state_reg == IDLE && accept_en_reg) ? grant : 2'b00;
    assign sel_id    = grant[1];
    assign handshake = |(req_valid & req_ready);

    alu32 u_alu (
        .a (a_reg),
        .b (b_reg),
        .f (op_reg),
        .y (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= 1'b0;
            accept_en_reg <= 1'b0;
            id_reg        <= 1'b0;
            op_err_reg    <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            op_reg        <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= 1'b0;
            rsp_y_reg     <= '0;
            rsp_err_reg   <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    accept_en_reg <= 1'b1;
                    if (handshake) begin
                        a_reg      <= a_arr[sel_id];
                        b_reg      <= b_arr[sel_id];
                        op_reg     <= op_arr[sel_id];
                        op_err_reg <= !$onehot(op_arr[sel_id]);
                        id_reg     <= sel_id;
                        rr_ptr_reg <= ~sel_id;
                        busy_reg   <= 1'b1;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_reg     <= op_err_reg ? '0 : alu_y;
                    rsp_err_reg   <= op_err_reg;
                    rsp_id_reg    <= id_reg;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = rsp_id_reg;
    assign rsp_y     = rsp_y_reg;
    assign rsp_err   = rsp_err_reg;
    assign busy      = busy_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: reset, single ops, bad op, backpressure,
// reset during execute, contention and round-robin alternation.
module tb_alu_share_arbiter;
    import alu_share_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2*DW-1:0]  req_a;
    logic [2*DW-1:0]  req_b;
    logic [2*OPW-1:0] req_op;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [DW-1:0]    rsp_y;
    logic             rsp_err;
    logic             busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int            grant_q[$];
    logic          rsp_id_q[$];
    logic [DW-1:0] rsp_y_q[$];
    int            rsp_cyc_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_share_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    task automatic set_req(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic [OPW-1:0] op);
        req_a[i*DW +: DW]   = a;
        req_b[i*DW +: DW]   = b;
        req_op[i*OPW +: OPW] = op;
        req_valid[i]        = 1'b1;
    endtask

    // Issue one op from requester i (rsp_ready assumed high) and capture its response.
    task automatic do_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OPW-1:0] op, output bit ok, output logic [DW-1:0] y,
                         output logic id, output logic err);
        int n;
        ok = 1'b0; y = '0; id = 1'b0; err = 1'b0;
        set_req(i, a, b, op);
        #1;
        n = 0;
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[i]) begin
            req_valid[i] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[i] = 1'b0;
        n = 0;
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (rsp_valid) begin
            ok = 1'b1; y = rsp_y; id = rsp_id; err = rsp_err;
        end
        @(negedge clk);
    endtask

    // Record grants and responses each cycle until n responses are seen.
    task automatic collect(input int n, output bit ok);
        int c;
        c = 0;
        while (rsp_y_q.size() < n && c < 400) begin
            @(negedge clk);
            c++;
            if (|(req_valid & req_ready)) grant_q.push_back(req_ready[1] ? 1 : 0);
            if (rsp_valid) begin
                rsp_id_q.push_back(rsp_id);
                rsp_y_q.push_back(rsp_y);
                rsp_cyc_q.push_back(cyc);
            end
        end
        ok = (rsp_y_q.size() >= n);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL reset_valid_busy: got %b%b expected 00", rsp_valid, busy); end
        tests++; if (rsp_y !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL reset_rsp: got y=%h id=%b err=%b expected 0/0/0", rsp_y, rsp_id, rsp_err); end
        req_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("[TB] reset checks done");
    endtask

    task automatic test_single_add();
        int n;
        rsp_ready = 1'b1;
        set_req(0, 32'd5, 32'd7, OP_ADD);
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        tests++; if (req_ready !== 2'b01) begin fails++; $display("FAIL add_accept: got req_ready=%b expected 01", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("FAIL add_exec: got valid=%b busy=%b ready=%b expected 0/1/00", rsp_valid, busy, req_ready); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL add_latency: got rsp_valid=%b expected 1", rsp_valid); end
        tests++; if (rsp_y !== 32'd12 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL add_result: got y=%h id=%b err=%b expected 0000000c/0/0", rsp_y, rsp_id, rsp_err); end
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL add_done: got valid=%b busy=%b expected 0/0", rsp_valid, busy); end
        $display("[TB] single add: y=%h id=%b", 32'd12, 1'b0);
    endtask

    task automatic test_bad_op();
        bit ok; logic [DW-1:0] y; logic id; logic err;
        rsp_ready = 1'b1;
        do_op(0, 32'd5, 32'd6, 12'b0000_0000_0011, ok, y, id, err);
        tests++; if (!ok || err !== 1'b1 || y !== '0 || id !== 1'b0) begin fails++; $display("FAIL bad_op: got ok=%0d y=%h id=%b err=%b expected 1/00000000/0/1", ok, y, id, err); end
        $display("[TB] bad op: y=%h err=%b", y, err);
    endtask

    task automatic test_ops();
        logic [DW-1:0]  ta [5];
        logic [DW-1:0]  tb [5];
        logic [OPW-1:0] top[5];
        logic [DW-1:0]  ty [5];
        bit ok; logic [DW-1:0] y; logic id; logic err;
        ta  = '{32'hFFFF_FFFF, 32'd5,         32'hF0F0_0000, 32'h8000_0000, 32'hFFFF_FFFF};
        tb  = '{32'd1,         32'd7,         32'h0FF0_0000, 32'd4,         32'd1};
        top = '{OP_ADD,        OP_SUB,        OP_XOR,        OP_SRA,        OP_SLT};
        ty  = '{32'h0000_0000, 32'hFFFF_FFFE, 32'hFF00_0000, 32'hF800_0000, 32'h0000_0001};
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            do_op((k % 2 == 0) ? 1 : 0, ta[k], tb[k], top[k], ok, y, id, err);
            tests++;
            if (!ok || y !== ty[k] || err !== 1'b0 || id !== ((k % 2 == 0) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL op_%0d: got ok=%0d y=%h id=%b err=%b expected y=%h err=0", k, ok, y, id, err, ty[k]);
            end
            $display("[TB] op %0d: a=%h b=%h op=%h y=%h", k, ta[k], tb[k], top[k], y);
        end
    endtask

    task automatic test_backpressure();
        int n;
        rsp_ready = 1'b0;
        set_req(0, 32'd10, 32'd20, OP_ADD);
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        req_valid[0] = 1'b0;
        set_req(1, 32'd3, 32'd4, OP_ADD);
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd30 || rsp_id !== 1'b0) begin fails++; $display("FAIL bp_first: got valid=%b y=%h id=%b expected 1/0000001e/0", rsp_valid, rsp_y, rsp_id); end
        for (int k = 0; k < 5; k++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_y !== 32'd30 || rsp_id !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold_%0d: got valid=%b y=%h id=%b ready=%b busy=%b expected 1/0000001e/0/00/1", k, rsp_valid, rsp_y, rsp_id, req_ready, busy);
            end
            if (k < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b10) begin fails++; $display("FAIL bp_release: got valid=%b busy=%b ready=%b expected 0/0/10", rsp_valid, busy, req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        tests++; if (rsp_valid !== 1'b1 || rsp_y !== 32'd7 || rsp_id !== 1'b1) begin fails++; $display("FAIL bp_second: got valid=%b y=%h id=%b expected 1/00000007/1", rsp_valid, rsp_y, rsp_id); end
        @(negedge clk);
        $display("[TB] backpressure: held 5 cycles, then y=%h id=%b", 32'd7, 1'b1);
    endtask

    task automatic test_reset_mid_exec();
        int n;
        bit seen;
        rsp_ready = 1'b1;
        set_req(0, 32'd100, 32'd200, OP_ADD);
        #1;
        n = 0;
        while (!req_ready[0] && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rst_exec_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_y !== '0 || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin fails++; $display("FAIL rst_exec_outputs: got busy=%b valid=%b y=%h id=%b err=%b expected all 0", busy, rsp_valid, rsp_y, rsp_id, rsp_err); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        tests++; if (seen) begin fails++; $display("FAIL rst_exec_no_rsp: got activity=1 expected 0"); end
        $display("[TB] reset mid-exec: in-flight op dropped");
    endtask

    task automatic test_contention();
        bit ok;
        grant_q.delete(); rsp_id_q.delete(); rsp_y_q.delete(); rsp_cyc_q.delete();
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        set_req(0, 32'd1, 32'd1, OP_ADD);
        set_req(1, 32'd2, 32'd2, OP_ADD);
        @(negedge clk);
        rst_n = 1'b1;
        collect(2, ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL contention_timeout: got %0d responses expected 2", rsp_y_q.size());
        end else begin
            if (rsp_id_q[0] !== 1'b0 || rsp_y_q[0] !== 32'd2) begin fails++; $display("FAIL contention_first: got id=%b y=%h expected 0/00000002", rsp_id_q[0], rsp_y_q[0]); end
            tests++;
            if (rsp_id_q[1] !== 1'b1 || rsp_y_q[1] !== 32'd4) begin fails++; $display("FAIL contention_second: got id=%b y=%h expected 1/00000004", rsp_id_q[1], rsp_y_q[1]); end
            $display("[TB] contention: id=%b y=%h, id=%b y=%h", rsp_id_q[0], rsp_y_q[0], rsp_id_q[1], rsp_y_q[1]);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        collect(22, ok);
        req_valid = 2'b00;
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL b2b_timeout: got %0d responses expected 22", rsp_y_q.size());
        end else begin
            for (int k = 2; k < 22; k++) begin
                tests++;
                if (rsp_id_q[k] !== k[0] || rsp_y_q[k] !== (k[0] ? 32'd4 : 32'd2)) begin
                    fails++;
                    $display("FAIL b2b_rsp_%0d: got id=%b y=%h expected id=%b", k, rsp_id_q[k], rsp_y_q[k], k[0]);
                end
                $display("[TB] b2b rsp %0d: id=%b y=%h", k, rsp_id_q[k], rsp_y_q[k]);
            end
            for (int k = 0; k < grant_q.size(); k++) begin
                tests++;
                if (grant_q[k] != (k % 2)) begin fails++; $display("FAIL b2b_grant_%0d: got %0d expected %0d", k, grant_q[k], k % 2); end
            end
            for (int k = 1; k < 22; k++) begin
                tests++;
                if (rsp_cyc_q[k] - rsp_cyc_q[k-1] != 3) begin fails++; $display("FAIL b2b_gap_%0d: got %0d cycles expected 3", k, rsp_cyc_q[k] - rsp_cyc_q[k-1]); end
            end
        end
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got busy=%b valid=%b expected 0/0", busy, rsp_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_add();
        test_bad_op();
        test_ops();
        test_backpressure();
        test_reset_mid_exec();
        test_contention();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
